// File: rtl/shift_mix_add_stage_if.sv
// Bundle for the ShiftRows/MixColumns/AddRoundKey stage: upstream word handshake,
// downstream result handshake and the completed-transfer counter.
interface shift_mix_add_stage_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         in_final;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         out_final;
    logic [15:0]  out_count;

    modport master (
        output in_valid, in_state, in_key, in_final, out_ready,
        input  in_ready, out_valid, out_state, out_final, out_count
    );

    modport slave (
        input  in_valid, in_state, in_key, in_final, out_ready,
        output in_ready, out_valid, out_state, out_final, out_count
    );
endinterface

// File: rtl/shift_mix_add_stage.sv
// AES round tail: ShiftRows -> MixColumns (bypassed on final round) -> XOR round key.
// Latency: 2 cycles accept-to-out_valid with REG_MID=1, 1 cycle with REG_MID=0.
// Backpressure: valid/ready per stage; in_ready is combinational from out_ready, full rate when unstalled.
module shift_mix_add_stage #(
    parameter int REG_MID = 1
) (
    input logic              clk,
    input logic              rst_n,
    shift_mix_add_stage_if.slave bus
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte k of the word sits at [127-8k -: 8]; column = k/4, row = k%4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    logic [127:0] sr_w;
    logic [127:0] mix_w;
    logic [127:0] lin_w;
    logic         accept;
    logic         xfer;
    logic [15:0]  out_count_q;

    assign sr_w   = shift_rows(bus.in_state);
    assign mix_w  = mix_columns(sr_w);
    assign lin_w  = bus.in_final ? sr_w : mix_w;
    assign accept = bus.in_valid && bus.in_ready;
    assign xfer   = bus.out_valid && bus.out_ready;

    generate
        if (REG_MID != 0) begin : g_two_stage
            logic         s1_vld;
            logic [127:0] s1_dat;
            logic [127:0] s1_key;
            logic         s1_fin;
            logic         s2_vld;
            logic [127:0] s2_dat;
            logic         s2_fin;
            logic         s2_open;
            logic         s1_adv;

            // Stage 2 can take a word if empty or draining this cycle.
            assign s2_open      = !s2_vld || bus.out_ready;
            assign s1_adv       = s1_vld && s2_open;
            assign bus.in_ready = !s1_vld || s1_adv;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_vld <= 1'b0;
                    s1_dat <= '0;
                    s1_key <= '0;
                    s1_fin <= 1'b0;
                end else begin
                    if (bus.in_ready) s1_vld <= bus.in_valid;
                    if (accept) begin
                        s1_dat <= lin_w;
                        s1_key <= bus.in_key;
                        s1_fin <= bus.in_final;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_vld <= 1'b0;
                    s2_dat <= '0;
                    s2_fin <= 1'b0;
                end else if (s2_open) begin
                    s2_vld <= s1_vld;
                    if (s1_adv) begin
                        s2_dat <= s1_dat ^ s1_key;
                        s2_fin <= s1_fin;
                    end
                end
            end

            assign bus.out_valid = s2_vld;
            assign bus.out_state = s2_dat;
            assign bus.out_final = s2_fin;
        end else begin : g_one_stage
            logic         s_vld;
            logic [127:0] s_dat;
            logic         s_fin;

            assign bus.in_ready = !s_vld || bus.out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_vld <= 1'b0;
                    s_dat <= '0;
                    s_fin <= 1'b0;
                end else begin
                    if (bus.in_ready) s_vld <= bus.in_valid;
                    if (accept) begin
                        s_dat <= lin_w ^ bus.in_key;
                        s_fin <= bus.in_final;
                    end
                end
            end

            assign bus.out_valid = s_vld;
            assign bus.out_state = s_dat;
            assign bus.out_final = s_fin;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count_q <= 16'd0;
        end else if (xfer) begin
            out_count_q <= out_count_q + 16'd1;
        end
    end

    assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_shift_mix_add_stage.sv
// Randomised and directed checks of shift_mix_add_stage (both REG_MID settings) against
// a byte-matrix AES reference model and an in-order scoreboard.
module tb_shift_mix_add_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_mix_add_stage_if a_if();
    shift_mix_add_stage_if b_if();

    shift_mix_add_stage #(.REG_MID(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    shift_mix_add_stage #(.REG_MID(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

    localparam logic [127:0] VEC_ST   = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] VEC_KEY  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] VEC_RND  = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] VEC_FIN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Plain GF(2^8) product: carry-less multiply then reduce by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] key,
                                               input logic fin);
        logic [7:0]   m  [4][4];
        logic [7:0]   sr [4][4];
        logic [7:0]   mx [4][4];
        logic [7:0]   mat[4];
        logic [127:0] res;
        mat = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = st[127-8*(4*c+r) -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                sr[r][c] = m[r][(c + r) % 4];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                mx[r][c] = 8'h00;
                for (int j = 0; j < 4; j++) mx[r][c] = mx[r][c] ^ gmul(mat[(j - r + 4) % 4], sr[j][c]);
            end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = (fin ? sr[r][c] : mx[r][c]) ^ key[127-8*(4*c+r) -: 8];
        return res;
    endfunction

    // Scoreboard for the REG_MID=1 instance: every accept queues its expected word.
    logic [127:0] exp_q[$];
    logic         expf_q[$];
    logic [15:0]  mdl_cnt = 16'd0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_if.out_valid && a_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_word", 1'b1, 1'b0);
                end else begin
                    check_eq("scb_state", a_if.out_state, exp_q.pop_front());
                    check_eq("scb_final", a_if.out_final, expf_q.pop_front());
                end
                mdl_cnt = mdl_cnt + 16'd1;
            end
            if (a_if.in_valid && a_if.in_ready) begin
                exp_q.push_back(ref_round(a_if.in_state, a_if.in_key, a_if.in_final));
                expf_q.push_back(a_if.in_final);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_word_a();
        a_if.in_state = {$urandom, $urandom, $urandom, $urandom};
        a_if.in_key   = {$urandom, $urandom, $urandom, $urandom};
        a_if.in_final = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || a_if.out_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check_eq("drain_timeout", 1'b1, 1'b0);
        @(negedge clk);
    endtask

    int acc;
    int run_n, run_first, run_last;
    logic [127:0] hold;
    logic held;
    int guard;

    initial begin
        a_if.in_valid = 0; a_if.in_state = '0; a_if.in_key = '0; a_if.in_final = 0; a_if.out_ready = 0;
        b_if.in_valid = 0; b_if.in_state = '0; b_if.in_key = '0; b_if.in_final = 0; b_if.out_ready = 0;

        // Reset state
        #12;
        check_eq("rst_a_vld", a_if.out_valid, 1'b0);
        check_eq("rst_a_state", a_if.out_state, '0);
        check_eq("rst_a_final", a_if.out_final, 1'b0);
        check_eq("rst_a_cnt", a_if.out_count, '0);
        check_eq("rst_b_vld", b_if.out_valid, 1'b0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_rdy_a", a_if.in_ready, 1'b1);
        check_eq("post_rst_rdy_b", b_if.in_ready, 1'b1);

        // REG_MID=0: FIPS vector with one cycle latency
        tick();
        b_if.out_ready = 1; b_if.in_valid = 1;
        b_if.in_state = VEC_ST; b_if.in_key = VEC_KEY; b_if.in_final = 0;
        @(negedge clk);
        check_eq("b_acc_rdy", b_if.in_ready, 1'b1);
        tick();
        b_if.in_valid = 0;
        @(negedge clk);
        check_eq("b_lat_vld", b_if.out_valid, 1'b1);
        check_eq("b_vec_state", b_if.out_state, VEC_RND);
        tick();
        @(negedge clk);
        check_eq("b_cnt1", b_if.out_count, 16'd1);
        // REG_MID=0 stall: only one word fits
        tick();
        b_if.out_ready = 0; b_if.in_valid = 1;
        b_if.in_state = {$urandom, $urandom, $urandom, $urandom};
        acc = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (b_if.in_ready) acc++;
            tick();
        end
        check_eq("b_stall_acc", 128'(acc), 128'd1);
        b_if.in_valid = 0; b_if.out_ready = 1;
        repeat (3) tick();
        @(negedge clk);
        check_eq("b_cnt2", b_if.out_count, 16'd2);

        // REG_MID=1: FIPS vector, two cycle latency
        tick();
        a_if.out_ready = 1; a_if.in_valid = 1;
        a_if.in_state = VEC_ST; a_if.in_key = VEC_KEY; a_if.in_final = 0;
        @(negedge clk);
        check_eq("a_acc_rdy", a_if.in_ready, 1'b1);
        tick();
        a_if.in_valid = 0;
        @(negedge clk);
        check_eq("a_lat_early", a_if.out_valid, 1'b0);
        @(negedge clk);
        check_eq("a_lat_vld", a_if.out_valid, 1'b1);
        check_eq("a_vec_state", a_if.out_state, VEC_RND);
        wait_drain();

        // Final round: ShiftRows only, zero key
        tick();
        a_if.in_valid = 1; a_if.in_state = VEC_ST; a_if.in_key = '0; a_if.in_final = 1;
        tick();
        a_if.in_valid = 0;
        @(negedge clk);
        @(negedge clk);
        check_eq("fin_vld", a_if.out_valid, 1'b1);
        check_eq("fin_state", a_if.out_state, VEC_FIN);
        check_eq("fin_flag", a_if.out_final, 1'b1);
        wait_drain();
        check_eq("cnt_after_vec", a_if.out_count, mdl_cnt);

        // Eight back-to-back words with no bubbles
        run_n = 0; run_first = -1; run_last = -1;
        tick();
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    a_if.in_valid = 1;
                    rand_word_a();
                    @(negedge clk);
                    check_eq("b2b_rdy", a_if.in_ready, 1'b1);
                    tick();
                end
                a_if.in_valid = 0;
            end
            begin
                for (int k = 0; k < 16; k++) begin
                    @(negedge clk);
                    if (a_if.out_valid) begin
                        run_n++;
                        if (run_first < 0) run_first = k;
                        run_last = k;
                    end
                end
            end
        join
        check_eq("b2b_count", 128'(run_n), 128'd8);
        check_eq("b2b_span", 128'(run_last - run_first + 1), 128'd8);
        wait_drain();
        check_eq("b2b_out_count", a_if.out_count, mdl_cnt);

        // Stall: two accepts then in_ready low, output stable
        tick();
        a_if.out_ready = 0; a_if.in_valid = 1; rand_word_a();
        acc = 0; held = 0; hold = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (a_if.out_valid) begin
                if (!held) begin hold = a_if.out_state; held = 1; end
                else check_eq("stall_stable", a_if.out_state, hold);
            end
            if (a_if.in_ready) acc++;
            tick();
            rand_word_a();
        end
        check_eq("stall_acc", 128'(acc), 128'd2);
        @(negedge clk);
        check_eq("stall_rdy_low", a_if.in_ready, 1'b0);
        tick();
        a_if.out_ready = 1;
        @(negedge clk);
        check_eq("full_pass_rdy", a_if.in_ready, 1'b1);
        tick();
        a_if.in_valid = 0;
        wait_drain();
        check_eq("stall_out_count", a_if.out_count, mdl_cnt);

        // Reset with two words in flight
        a_if.out_ready = 0; a_if.in_valid = 1; rand_word_a();
        for (int k = 0; k < 2; k++) begin
            tick();
            rand_word_a();
        end
        a_if.in_valid = 0;
        tick();
        rst_n = 0;
        #1;
        check_eq("midrst_vld", a_if.out_valid, 1'b0);
        check_eq("midrst_cnt", a_if.out_count, '0);
        check_eq("midrst_state", a_if.out_state, '0);
        exp_q.delete(); expf_q.delete(); mdl_cnt = 16'd0;
        tick();
        a_if.out_ready = 1;
        rst_n = 1;
        @(negedge clk);
        check_eq("midrst_rdy", a_if.in_ready, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("no_stale", a_if.out_valid, 1'b0);
        end

        // out_count wrap: 65535 transfers, then one more
        tick();
        acc = 0; guard = 0;
        a_if.in_valid = 1;
        while (acc < 65535 && guard < 70000) begin
            rand_word_a();
            @(negedge clk);
            if (a_if.in_ready) acc++;
            guard++;
            tick();
        end
        a_if.in_valid = 0;
        check_eq("wrap_feed", 128'(acc), 128'd65535);
        wait_drain();
        check_eq("cnt_ffff", a_if.out_count, 16'hffff);
        check_eq("cnt_ffff_mdl", a_if.out_count, mdl_cnt);
        tick();
        a_if.in_valid = 1; rand_word_a();
        tick();
        a_if.in_valid = 0;
        wait_drain();
        check_eq("cnt_wrap", a_if.out_count, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_mix_add_stage.md
SHIFT_MIX_ADD_STAGE -- requirements
Module: shift_mix_add_stage

Interface
REQ-001 The block SHALL have parameter REG_MID, default 1; 1 = register after MixColumns (latency 2), 0 = no middle register (latency 1).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  upstream (SubBytes output) word valid.
REQ-005 in_ready  out  1  block accepts the word this cycle.
REQ-006 in_state  in  128  SubBytes result; [127:96] = column 0, MSB byte of each column = row 0.
REQ-007 in_key  in  128  round key, same byte layout, sampled with in_state.
REQ-008 in_final  in  1  final round: skip MixColumns.
REQ-009 out_valid  out  1  out_state valid.
REQ-010 out_ready  in  1  downstream accepts.
REQ-011 out_state  out  128  ShiftRows -> MixColumns (unless final) -> XOR key.
REQ-012 out_final  out  1  in_final carried with its word.
REQ-013 out_count  out  16  number of completed output handshakes.

Function
REQ-014 Accept SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-015 ShiftRows SHALL rotate row r left by r bytes, r = 0..3.
REQ-016 MixColumns SHALL use the FIPS-197 matrix {02,03,01,01} over GF(2^8), reduction polynomial 0x11B.
REQ-017 When in_final = 1, out_state SHALL be ShiftRows(in_state) XOR in_key.
REQ-018 REG_MID=1: stage 1 SHALL register ShiftRows/MixColumns output plus key and final; stage 2 SHALL register the XOR result; latency from accept to out_valid SHALL be 2 cycles.
REQ-019 REG_MID=0: a single stage SHALL register the full result; latency SHALL be 1 cycle.
REQ-020 Each stage SHALL hold a valid bit; a stage SHALL load when it is empty or its contents move forward in the same cycle.
REQ-021 in_ready SHALL equal NOT(stage-1 valid) OR (stage 1 advancing this cycle); it SHALL be combinational from out_ready and contain no in_valid term.
REQ-022 With out_ready held at 1, the block SHALL sustain one word per cycle with no bubbles.
REQ-023 While out_valid && !out_ready, out_state and out_final SHALL hold stable and no word SHALL be dropped or duplicated.
REQ-024 When full, the block SHALL accept a new word in the same cycle the oldest word transfers out.
REQ-025 Words SHALL leave in acceptance order.
REQ-026 in_state, in_key and in_final SHALL be ignored when no accept occurs.
REQ-027 out_count SHALL increment by 1 per output transfer and wrap from 0xFFFF to 0x0000.

Reset
REQ-028 While rst_n = 0, all stage valids, out_valid and out_final SHALL be 0, and out_state and out_count SHALL be 0, regardless of clk.
REQ-029 If reset is asserted mid-operation, all in-flight words SHALL be discarded.
REQ-030 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-031 Bench SHALL cover the following scenarios:
- in_state=d42711aee0bf98f1b8b45de51e415230, in_key=a0fafe1788542cb123a339392a6c7605, in_final=0, out_ready=1 -> out_state=a49c7ff2689f352b6b5bea43026a5049, 2 cycles later (REG_MID=1).
- Same in_state, in_key=0, in_final=1 -> out_state=d4bf5d30e0b452aeb84111f11e2798e5, out_final=1.
- 8 back-to-back words with out_ready=1 -> 8 consecutive out_valid cycles, in order, out_count=8.
- out_ready=0 while driving words -> in_ready falls after 2 accepts (REG_MID=1) and out_state stays stable; raise out_ready -> both words drain in order, no loss.
- Reset asserted with 2 words in flight -> out_valid=0 and out_count=0 immediately; no stale word appears after release.
- Preload out_count=0xFFFF via 65535 transfers, then 1 more transfer -> out_count=0x0000.
- Repeat the first scenario with REG_MID=0 -> same result 1 cycle after accept.
